// File: rtl/cti_pkg.sv
// ============================================================================
// Module      : cti_pkg
// Description : Shared encodings for the control-transfer unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cti_pkg;

    localparam logic [2:0] c_F3_BEQ  = 3'b000;
    localparam logic [2:0] c_F3_BNE  = 3'b001;
    localparam logic [2:0] c_F3_BLT  = 3'b100;
    localparam logic [2:0] c_F3_BGE  = 3'b101;
    localparam logic [2:0] c_F3_BLTU = 3'b110;
    localparam logic [2:0] c_F3_BGEU = 3'b111;

    localparam logic [4:0] c_LINK_X1 = 5'd1;
    localparam logic [4:0] c_LINK_X5 = 5'd5;

    typedef enum logic [1:0] {
        RAS_NONE    = 2'd0,
        RAS_PUSH    = 2'd1,
        RAS_POP     = 2'd2,
        RAS_POPPUSH = 2'd3
    } ras_op_e;

    function automatic logic is_link(input logic [4:0] idx);
        return (idx == c_LINK_X1) || (idx == c_LINK_X5);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ras_stack.sv
// ============================================================================
// Module      : ras_stack
// Description : Circular return-address stack with saturating occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_stack
    import cti_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  ras_op_e         i_op,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_top,
    output logic            o_valid
);

    localparam int              c_PW   = $clog2(RAS_DEPTH);
    localparam logic [c_PW-1:0] c_PONE = c_PW'(1);
    localparam logic [c_PW:0]   c_CONE = (c_PW + 1)'(1);
    localparam logic [c_PW:0]   c_FULL = (c_PW + 1)'(RAS_DEPTH);

    logic [XLEN-1:0] r_entries [RAS_DEPTH];
    logic [c_PW-1:0] r_ptr;
    logic [c_PW:0]   r_count;

    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_replace;
    logic [c_PW-1:0] w_top_idx;

    assign w_empty   = (r_count == '0);
    assign w_top_idx = r_ptr - c_PONE;

    // A pop-then-push on an empty stack degenerates to a plain push.
    always_comb begin
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_replace = 1'b0;
        case (i_op)
            RAS_PUSH:    w_push = 1'b1;
            RAS_POP:     w_pop  = !w_empty;
            RAS_POPPUSH: begin
                w_replace = !w_empty;
                w_push    = w_empty;
            end
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_entries[r_ptr] <= i_data;
        end else if (w_replace) begin
            r_entries[w_top_idx] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (w_push) begin
            r_ptr <= r_ptr + c_PONE;
            if (r_count != c_FULL) begin
                r_count <= r_count + c_CONE;
            end
        end else if (w_pop) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - c_CONE;
        end
    end

    assign o_top   = w_empty ? '0 : r_entries[w_top_idx];
    assign o_valid = !w_empty;

endmodule

`default_nettype wire

// File: rtl/cti_unit.sv
// ============================================================================
// Module      : cti_unit
// Description : Resolves JAL/JALR/branches, link and RAS hints, registered out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cti_unit
    import cti_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4,
    parameter int SUPPORT_C = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inValid,
    output logic            inReady,
    input  logic            isJAL,
    input  logic            isJALR,
    input  logic            isBranch,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rdIdx,
    input  logic [4:0]      rs1Idx,
    input  logic [XLEN-1:0] rs1Val,
    input  logic [XLEN-1:0] rs2Val,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] currentPC,
    input  logic            flush,
    output logic            outValid,
    input  logic            outReady,
    output logic            redirect,
    output logic [XLEN-1:0] targetPC,
    output logic            linkWe,
    output logic [XLEN-1:0] linkReg,
    output logic            misalignExc,
    output logic            illegalFunct3,
    output logic [XLEN-1:0] rasTop,
    output logic            rasValid
);

    localparam logic [XLEN-1:0] c_CLR_BIT0 = {{(XLEN - 1){1'b1}}, 1'b0};
    localparam logic [XLEN-1:0] c_FOUR     = XLEN'(4);

    logic            r_out_valid;
    logic            r_redirect;
    logic [XLEN-1:0] r_target;
    logic            r_link_we;
    logic [XLEN-1:0] r_link;
    logic            r_misalign;
    logic            r_illegal;

    logic            w_in_ready;
    logic            w_accept;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_link;
    logic            w_cond;
    logic            w_illegal;
    logic            w_taken;
    logic            w_misalign;
    logic            w_link_we;
    logic            w_rd_link;
    logic            w_rs1_link;
    ras_op_e         w_ras_op;
    ras_op_e         w_ras_op_acc;

    // flush takes priority over any transfer offered in the same cycle
    assign w_in_ready = (!r_out_valid || outReady) && !flush;
    assign w_accept   = inValid && w_in_ready;

    assign w_target = isJALR ? ((rs1Val + imm) & c_CLR_BIT0) : (currentPC + imm);
    assign w_link   = currentPC + c_FOUR;

    always_comb begin
        w_cond    = 1'b0;
        w_illegal = 1'b0;
        case (funct3)
            c_F3_BEQ:  w_cond = (rs1Val == rs2Val);
            c_F3_BNE:  w_cond = (rs1Val != rs2Val);
            c_F3_BLT:  w_cond = ($signed(rs1Val) <  $signed(rs2Val));
            c_F3_BGE:  w_cond = ($signed(rs1Val) >= $signed(rs2Val));
            c_F3_BLTU: w_cond = (rs1Val <  rs2Val);
            c_F3_BGEU: w_cond = (rs1Val >= rs2Val);
            default:   w_illegal = 1'b1;
        endcase
    end

    assign w_taken    = isJAL || isJALR || (isBranch && w_cond);
    assign w_misalign = w_taken && (SUPPORT_C == 0) && w_target[1];
    assign w_link_we  = (isJAL || isJALR) && (rdIdx != 5'd0) && !w_misalign;

    assign w_rd_link  = is_link(rdIdx);
    assign w_rs1_link = is_link(rs1Idx);

    always_comb begin
        w_ras_op = RAS_NONE;
        if (!w_misalign) begin
            if (isJAL) begin
                w_ras_op = w_rd_link ? RAS_PUSH : RAS_NONE;
            end else if (isJALR) begin
                case ({w_rd_link, w_rs1_link})
                    2'b01:   w_ras_op = RAS_POP;
                    2'b10:   w_ras_op = RAS_PUSH;
                    2'b11:   w_ras_op = (rdIdx == rs1Idx) ? RAS_PUSH : RAS_POPPUSH;
                    default: w_ras_op = RAS_NONE;
                endcase
            end
        end
    end

    assign w_ras_op_acc = w_accept ? w_ras_op : RAS_NONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_redirect  <= 1'b0;
            r_target    <= '0;
            r_link_we   <= 1'b0;
            r_link      <= '0;
            r_misalign  <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_redirect  <= w_taken && !w_misalign;
            r_target    <= w_target;
            r_link_we   <= w_link_we;
            r_link      <= w_link;
            r_misalign  <= w_misalign;
            r_illegal   <= isBranch && w_illegal;
        end else if (outReady) begin
            r_out_valid <= 1'b0;
        end
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_op    (w_ras_op_acc),
        .i_data  (w_link),
        .o_top   (rasTop),
        .o_valid (rasValid)
    );

    assign inReady       = w_in_ready;
    assign outValid      = r_out_valid;
    assign redirect      = r_redirect;
    assign targetPC      = r_target;
    assign linkWe        = r_link_we;
    assign linkReg       = r_link;
    assign misalignExc   = r_misalign;
    assign illegalFunct3 = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_cti_unit.sv
// ============================================================================
// Module      : tb_cti_unit
// Description : Directed self-checking bench for cti_unit (XLEN=32, depth 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cti_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid, inReady;
    logic        isJAL, isJALR, isBranch;
    logic [2:0]  funct3;
    logic [4:0]  rdIdx, rs1Idx;
    logic [31:0] rs1Val, rs2Val, imm, currentPC;
    logic        flush, outValid, outReady;
    logic        redirect, linkWe, misalignExc, illegalFunct3, rasValid;
    logic [31:0] targetPC, linkReg, rasTop;

    int r_checks = 0;
    int r_passed = 0;

    always #5 clk = ~clk;

    cti_unit #(.XLEN(32), .RAS_DEPTH(4), .SUPPORT_C(0)) dut (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
        .isJAL(isJAL), .isJALR(isJALR), .isBranch(isBranch), .funct3(funct3),
        .rdIdx(rdIdx), .rs1Idx(rs1Idx), .rs1Val(rs1Val), .rs2Val(rs2Val),
        .imm(imm), .currentPC(currentPC), .flush(flush), .outValid(outValid),
        .outReady(outReady), .redirect(redirect), .targetPC(targetPC),
        .linkWe(linkWe), .linkReg(linkReg), .misalignExc(misalignExc),
        .illegalFunct3(illegalFunct3), .rasTop(rasTop), .rasValid(rasValid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        r_checks++;
        if (got === exp) r_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic set_in(input logic jal, jalr, br, input logic [2:0] f3,
                          input logic [4:0] rd, rs1, input logic [31:0] v1, v2, im, pc);
        isJAL = jal; isJALR = jalr; isBranch = br; funct3 = f3;
        rdIdx = rd; rs1Idx = rs1; rs1Val = v1; rs2Val = v2; imm = im; currentPC = pc;
    endtask

    // present one instruction for one edge, then sample just after it
    task automatic send(input logic jal, jalr, br, input logic [2:0] f3,
                        input logic [4:0] rd, rs1, input logic [31:0] v1, v2, im, pc);
        set_in(jal, jalr, br, f3, rd, rs1, v1, v2, im, pc);
        inValid  = 1'b1;
        outReady = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; inValid = 1'b0; flush = 1'b0; outReady = 1'b1;
        set_in(0, 0, 0, 3'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_outValid", outValid, 0);
        check("rst_targetPC", targetPC, 0);
        check("rst_linkReg", linkReg, 0);
        check("rst_rasValid", rasValid, 0);
        check("rst_rasTop", rasTop, 0);
        check("rst_inReady", inReady, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // JAL with link: push return address
        send(1, 0, 0, 3'd0, 5'd1, 5'd0, 0, 0, 32'h40, 32'h100);
        check("jal_outValid", outValid, 1);
        check("jal_redirect", redirect, 1);
        check("jal_target", targetPC, 32'h140);
        check("jal_link", linkReg, 32'h104);
        check("jal_linkWe", linkWe, 1);
        check("jal_rasTop", rasTop, 32'h104);
        check("jal_rasValid", rasValid, 1);

        // JALR return: pop, then pop on empty
        send(0, 1, 0, 3'd0, 5'd0, 5'd1, 32'h104, 0, 32'h0, 32'h140);
        check("ret_target", targetPC, 32'h104);
        check("ret_linkWe", linkWe, 0);
        check("ret_redirect", redirect, 1);
        check("ret_rasValid", rasValid, 0);
        send(0, 1, 0, 3'd0, 5'd0, 5'd1, 32'h104, 0, 32'h0, 32'h140);
        check("pop_empty_rasValid", rasValid, 0);
        send(1, 0, 0, 3'd0, 5'd5, 5'd0, 0, 0, 32'h40, 32'h204);
        check("push_after_empty_top", rasTop, 32'h208);
        send(0, 1, 0, 3'd0, 5'd0, 5'd5, 32'h208, 0, 32'h0, 32'h300);
        check("pop_after_empty_valid", rasValid, 0);

        // JALR clears bit 0; non-link registers leave RAS alone
        send(0, 1, 0, 3'd0, 5'd0, 5'd2, 32'h301, 0, 32'h0, 32'h10);
        check("jalr_bit0_target", targetPC, 32'h300);
        check("jalr_nolink_ras", rasValid, 0);

        // branches
        send(0, 0, 1, 3'b100, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h10, 32'h200);
        check("blt_redirect", redirect, 1);
        check("blt_target", targetPC, 32'h210);
        check("blt_linkWe", linkWe, 0);
        send(0, 0, 1, 3'b110, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h10, 32'h200);
        check("bltu_redirect", redirect, 0);
        send(0, 0, 1, 3'b111, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h10, 32'h200);
        check("bgeu_redirect", redirect, 1);
        send(0, 0, 1, 3'b001, 5'd0, 5'd0, 32'h5, 32'h5, 32'h10, 32'h200);
        check("bne_eq_redirect", redirect, 0);
        send(0, 0, 1, 3'b000, 5'd0, 5'd0, 32'h5, 32'h5, 32'hFFFF_FFF0, 32'h200);
        check("beq_back_target", targetPC, 32'h1F0);
        check("beq_redirect", redirect, 1);
        send(0, 0, 1, 3'b010, 5'd0, 5'd0, 32'h5, 32'h5, 32'h10, 32'h200);
        check("f3_010_illegal", illegalFunct3, 1);
        check("f3_010_redirect", redirect, 0);

        // misaligned JAL
        send(1, 0, 0, 3'd0, 5'd1, 5'd0, 0, 0, 32'h2, 32'h100);
        check("mis_exc", misalignExc, 1);
        check("mis_redirect", redirect, 0);
        check("mis_linkWe", linkWe, 0);
        check("mis_ras", rasValid, 0);
        check("mis_illegal_clear", illegalFunct3, 0);

        // pop-then-push replaces top without growing
        send(1, 0, 0, 3'd0, 5'd1, 5'd0, 0, 0, 32'h40, 32'h9C);
        send(0, 1, 0, 3'd0, 5'd5, 5'd1, 32'hA0, 0, 32'h0, 32'h200);
        check("poppush_top", rasTop, 32'h204);
        check("poppush_linkWe", linkWe, 1);
        send(0, 1, 0, 3'd0, 5'd0, 5'd1, 32'h204, 0, 32'h0, 32'h300);
        check("poppush_count1", rasValid, 0);

        // five pushes into a depth-4 stack, then four pops
        for (int i = 0; i < 5; i++) begin
            send(1, 0, 0, 3'd0, 5'd1, 5'd0, 0, 0, 32'h40, 32'h0C + 32'h10 * i);
        end
        check("ovf_top0", rasTop, 32'h50);
        send(0, 1, 0, 3'd0, 5'd0, 5'd1, 32'h80, 0, 32'h0, 32'h0);
        check("ovf_top1", rasTop, 32'h40);
        send(0, 1, 0, 3'd0, 5'd0, 5'd1, 32'h80, 0, 32'h0, 32'h0);
        check("ovf_top2", rasTop, 32'h30);
        send(0, 1, 0, 3'd0, 5'd0, 5'd1, 32'h80, 0, 32'h0, 32'h0);
        check("ovf_top3", rasTop, 32'h20);
        check("ovf_valid3", rasValid, 1);
        send(0, 1, 0, 3'd0, 5'd0, 5'd1, 32'h80, 0, 32'h0, 32'h0);
        check("ovf_empty", rasValid, 0);

        // drain, then backpressure
        @(posedge clk); #1;
        check("drained_outValid", outValid, 0);
        set_in(1, 0, 0, 3'd0, 5'd0, 5'd0, 0, 0, 32'h10, 32'h500);
        inValid = 1'b1; outReady = 1'b0;
        @(posedge clk); #1;
        set_in(1, 0, 0, 3'd0, 5'd1, 5'd0, 0, 0, 32'h10, 32'h600);
        for (int i = 0; i < 3; i++) begin
            check("bp_inReady", inReady, 0);
            check("bp_target", targetPC, 32'h510);
            check("bp_outValid", outValid, 1);
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_outValid", outValid, 0);
        check("flush_ras", rasValid, 0);
        @(posedge clk); #1;
        inValid = 1'b0;
        check("after_flush_target", targetPC, 32'h610);
        check("after_flush_rasTop", rasTop, 32'h604);

        // asynchronous reset mid-stream
        rst_n = 1'b0;
        #1;
        check("arst_outValid", outValid, 0);
        check("arst_target", targetPC, 0);
        check("arst_linkWe", linkWe, 0);
        check("arst_rasValid", rasValid, 0);
        check("arst_rasTop", rasTop, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // flush and accept together: flush wins, no RAS update
        outReady = 1'b1;
        set_in(1, 0, 0, 3'd0, 5'd1, 5'd0, 0, 0, 32'h10, 32'h700);
        inValid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0; flush = 1'b0;
        check("flush_acc_outValid", outValid, 0);
        check("flush_acc_ras", rasValid, 0);

        $display("%0d/%0d checks passed", r_passed, r_checks);
        $finish;
    end

endmodule

`default_nettype wire
